// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: valid/ready byte port between a producer and the UART transmitter
//   data_in        byte offered by the producer
//   data_in_valid  producer offers data_in this cycle
//   data_in_ready  transmitter accepts data_in this cycle
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  modport master (output data_in, data_in_valid, input data_in_ready);
  modport slave  (input data_in, data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART TX with a byte FIFO fed by a valid/ready port, back-to-back frames
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   in_if         slave side of the byte push port (data_in / data_in_valid / data_in_ready)
//   serial_out_o  registered TX line, idle high
//   busy_o        frame in progress or FIFO non-empty
//   fifo_count_o  bytes queued, excluding the frame being sent
module uart_transmitter #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_transmitter_if.slave             in_if,
  output logic                          serial_out_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  if (CPB < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_transmitter: need CLK_FREQ/BAUD >= 2 and FIFO_DEPTH a power of two >= 2");
  end
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;
  logic            push, pop, full, baud_last;
  assign full                = cnt_q == (AW+1)'(FIFO_DEPTH);
  // ready is gated by rst so nothing is accepted while reset is held
  assign in_if.data_in_ready = !full && rst;
  assign push                = in_if.data_in_valid && in_if.data_in_ready;
  assign baud_last           = baud_q == CW'(CPB - 1);
  assign serial_out_o        = tx_q;
  assign busy_o              = state_q != IDLE || cnt_q != '0;
  assign fifo_count_o        = cnt_q;
  // tx_d is the line value for the next cycle, so serial_out stays a pure flop output
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = START;
          shift_d = mem_q[rd_q];
          tx_d    = 1'b0;
        end
      end
      START: if (baud_last) begin
        state_d = DATA;
        bit_d   = '0;
        baud_d  = '0;
        tx_d    = shift_q[0];
      end
      DATA: if (baud_last) begin
        baud_d  = '0;
        bit_d   = bit_q + 3'd1;
        shift_d = {1'b0, shift_q[7:1]};
        tx_d    = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (baud_last) begin
        baud_d  = '0;
        pop     = cnt_q != '0;
        state_d = pop ? START : IDLE;
        tx_d    = !pop;
        shift_d = pop ? mem_q[rd_q] : shift_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_if.data_in;
  end
endmodule
